// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin front end for a single-port 512x64 SRAM macro.
// Zero-fills the array after reset, then arbitrates one registered access per cycle.
module sram_port_arbiter #(
    parameter int BITS          = 64,
    parameter int WORD_DEPTH    = 512,
    parameter int ADDR_WIDTH    = 9,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [1:0]              req_v_i,
    output logic [1:0]              req_ready_o,
    input  logic [1:0]              req_we_i,
    input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2*BITS-1:0]       req_wdata_i,
    input  logic [2*BITS-1:0]       req_wmask_i,
    output logic [1:0]              resp_v_o,
    output logic [2*BITS-1:0]       resp_data_o,
    input  logic [1:0]              resp_ready_i,
    output logic                    init_done_o,
    output logic                    sram_ce_o,
    output logic                    sram_we_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [BITS-1:0]         sram_wd_o,
    output logic [BITS-1:0]         sram_wmask_o,
    input  logic [BITS-1:0]         sram_rd_i
);

    typedef enum logic {INIT, RUN} state_e;

    localparam state_e RESET_STATE = (INIT_ON_RESET != 0) ? INIT : RUN;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   initCnt_q, initCnt_d;
    logic                    rrPtr_q, rrPtr_d;
    logic [1:0]              outstanding_q, outstanding_d;
    logic                    initDone_q, initDone_d;
    logic                    sramCe_q, sramCe_d;
    logic                    sramWe_q, sramWe_d;
    logic [ADDR_WIDTH-1:0]   sramAddr_q, sramAddr_d;
    logic [BITS-1:0]         sramWd_q, sramWd_d;
    logic [BITS-1:0]         sramWmask_q, sramWmask_d;
    logic                    issV_q, issV_d;
    logic                    issR_q, issR_d;
    logic                    capV_q, capR_q;
    logic [1:0]              respV_q, respV_d;
    logic [2*BITS-1:0]       respData_q;

    logic [1:0]              consume;
    logic [1:0]              eligible;
    logic [1:0]              grant;
    logic                    gntIdx;

    // A read may only enter while its previous response is gone or leaving this cycle.
    always_comb begin
        consume  = respV_q & resp_ready_i;
        eligible = '0;
        grant    = '0;
        if (state_q == RUN && reset_n) begin
            for (int r = 0; r < 2; r++) begin
                eligible[r] = req_v_i[r] & (req_we_i[r] | ~outstanding_q[r] | consume[r]);
            end
        end
        case (eligible)
            2'b11:   grant = rrPtr_q ? 2'b10 : 2'b01;
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
        gntIdx = grant[1];

        rrPtr_d = rrPtr_q;
        if (|grant) begin
            rrPtr_d = ~gntIdx;
        end

        for (int r = 0; r < 2; r++) begin
            outstanding_d[r] = outstanding_q[r];
            if (grant[r] && !req_we_i[r]) begin
                outstanding_d[r] = 1'b1;
            end else if (consume[r]) begin
                outstanding_d[r] = 1'b0;
            end
        end

        respV_d = respV_q & ~consume;
        if (capV_q) begin
            respV_d[capR_q] = 1'b1;
        end

        state_d     = state_q;
        initCnt_d   = initCnt_q;
        initDone_d  = initDone_q | (state_q == RUN);
        sramCe_d    = 1'b0;
        sramWe_d    = 1'b0;
        sramAddr_d  = sramAddr_q;
        sramWd_d    = sramWd_q;
        sramWmask_d = sramWmask_q;
        issV_d      = 1'b0;
        issR_d      = issR_q;

        if (state_q == INIT) begin
            sramCe_d    = 1'b1;
            sramWe_d    = 1'b1;
            sramAddr_d  = initCnt_q;
            sramWd_d    = '0;
            sramWmask_d = '1;
            initCnt_d   = initCnt_q + 1'b1;
            if (initCnt_q == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
                state_d = RUN;
            end
        end else if (|grant) begin
            sramCe_d    = 1'b1;
            sramWe_d    = req_we_i[gntIdx];
            sramAddr_d  = gntIdx ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
            sramWd_d    = gntIdx ? req_wdata_i[2*BITS-1:BITS] : req_wdata_i[BITS-1:0];
            sramWmask_d = gntIdx ? req_wmask_i[2*BITS-1:BITS] : req_wmask_i[BITS-1:0];
            issV_d      = ~req_we_i[gntIdx];
            issR_d      = gntIdx;
        end
    end

    // Read tags trail the macro by one stage so sram_rd_i is sampled only when valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RESET_STATE;
            initCnt_q     <= '0;
            rrPtr_q       <= 1'b0;
            outstanding_q <= '0;
            initDone_q    <= 1'b0;
            sramCe_q      <= 1'b0;
            sramWe_q      <= 1'b0;
            sramAddr_q    <= '0;
            sramWd_q      <= '0;
            sramWmask_q   <= '0;
            issV_q        <= 1'b0;
            issR_q        <= 1'b0;
            capV_q        <= 1'b0;
            capR_q        <= 1'b0;
            respV_q       <= '0;
            respData_q    <= '0;
        end else begin
            state_q       <= state_d;
            initCnt_q     <= initCnt_d;
            rrPtr_q       <= rrPtr_d;
            outstanding_q <= outstanding_d;
            initDone_q    <= initDone_d;
            sramCe_q      <= sramCe_d;
            sramWe_q      <= sramWe_d;
            sramAddr_q    <= sramAddr_d;
            sramWd_q      <= sramWd_d;
            sramWmask_q   <= sramWmask_d;
            issV_q        <= issV_d;
            issR_q        <= issR_d;
            capV_q        <= issV_q;
            capR_q        <= issR_q;
            respV_q       <= respV_d;
            if (capV_q) begin
                if (capR_q) begin
                    respData_q[2*BITS-1:BITS] <= sram_rd_i;
                end else begin
                    respData_q[BITS-1:0] <= sram_rd_i;
                end
            end
        end
    end

    assign req_ready_o  = grant;
    assign resp_v_o     = respV_q;
    assign resp_data_o  = respData_q;
    assign init_done_o  = initDone_q;
    assign sram_ce_o    = sramCe_q;
    assign sram_we_o    = sramWe_q;
    assign sram_addr_o  = sramAddr_q;
    assign sram_wd_o    = sramWd_q;
    assign sram_wmask_o = sramWmask_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 512x64 masked-write macro.
module tb_sram_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 64;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] PAT_A = 64'hDEAD_BEEF_0123_4567;
    localparam logic [DW-1:0] PAT_M = 64'h0000_0000_FFFF_0000;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [1:0]      req_v, req_we, req_ready, resp_v, resp_ready;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata, req_wmask, resp_data;
    logic            init_done, sram_ce, sram_we;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wd, sram_wmask, sram_rd;

    logic [DW-1:0]   mem [0:511];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int expPtr = 0;

    sram_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req_v_i(req_v), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
        .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_ready_i(resp_ready),
        .init_done_o(init_done),
        .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wd_o(sram_wd), .sram_wmask_o(sram_wmask), .sram_rd_i(sram_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Macro model: registered read, bitwise write mask, undefined output after non-reads.
    always @(posedge clk) begin
        if (sram_ce && sram_we)
            mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
        if (sram_ce && !sram_we)
            sram_rd <= mem[sram_addr];
        else
            sram_rd <= 'x;
    end

    task automatic issueReq(input int r, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] m, output int acc);
        bit got = 0;
        int n = 0;
        @(negedge clk);
        req_we[r] = we;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
        req_wmask[r*DW +: DW] = m;
        req_v[r] = 1'b1;
        while (!got && n < 20) begin
            #1;
            if (req_ready[r] === 1'b1) got = 1;
            else begin n++; @(negedge clk); end
        end
        if (!got) begin
            checks++; failures++;
            $display("[TB] FAIL accept_timeout: requester %0d ready=%b required 1", r, req_ready[r]);
        end
        @(posedge clk);
        #1;
        req_v[r] = 1'b0;
        acc = cyc;
        expPtr = 1 - r;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_v = 2'b11; req_we = 2'b00; req_addr = '0;
        req_wdata = '0; req_wmask = '0; resp_ready = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({req_ready, resp_v, resp_data, init_done, sram_ce, sram_we, sram_addr, sram_wd, sram_wmask} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: ready=%b rv=%b done=%b ce=%b we=%b addr=%0d required all zero",
                     req_ready, resp_v, init_done, sram_ce, sram_we, sram_addr);
        end
        req_v = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            checks++;
            if ({sram_ce, sram_we, sram_addr, sram_wd, sram_wmask, init_done} !== {1'b1, 1'b1, AW'(i), {DW{1'b0}}, ONES, 1'b0}) begin
                failures++;
                $display("[TB] FAIL sweep_%0d: ce=%b we=%b addr=%0d wd=%h mask=%h done=%b required 1 1 %0d 0 ones 0",
                         i, sram_ce, sram_we, sram_addr, sram_wd, sram_wmask, init_done, i);
            end
        end
        @(negedge clk);
        checks++;
        if ({init_done, sram_ce} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL sweep_done: done=%b ce=%b required 1 0", init_done, sram_ce);
        end
        cyc = cyc;
    endtask

    task automatic test_read_zero();
        int a;
        issueReq(0, 1'b0, 9'd100, '0, '0, a);
        @(negedge clk);
        checks++;
        if ({sram_ce, sram_we, sram_addr, resp_v[0]} !== {1'b1, 1'b0, 9'd100, 1'b0}) begin
            failures++;
            $display("[TB] FAIL read0_issue: ce=%b we=%b addr=%0d rv=%b required 1 0 100 0", sram_ce, sram_we, sram_addr, resp_v[0]);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({resp_v[0], resp_data[DW-1:0]} !== {1'b1, {DW{1'b0}}}) begin
            failures++;
            $display("[TB] FAIL read_zero: rv=%b data=%h required 1 0", resp_v[0], resp_data[DW-1:0]);
        end
    endtask

    task automatic test_write_read();
        int a;
        issueReq(0, 1'b1, 9'd5, PAT_A, ONES, a);
        issueReq(0, 1'b0, 9'd5, '0, '0, a);
        @(negedge clk);
        checks++;
        if (resp_v[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_t1: rv=%b required 0", resp_v[0]);
        end
        @(negedge clk);
        checks++;
        if (resp_v[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_t2: rv=%b required 0", resp_v[0]);
        end
        @(negedge clk);
        checks++;
        if ({resp_v[0], resp_data[DW-1:0]} !== {1'b1, PAT_A}) begin
            failures++;
            $display("[TB] FAIL write_read: rv=%b data=%h required 1 %h", resp_v[0], resp_data[DW-1:0], PAT_A);
        end
    endtask

    task automatic test_partial_mask();
        int a;
        issueReq(1, 1'b1, 9'd7, ONES, PAT_M, a);
        @(negedge clk);
        checks++;
        if ({sram_ce, sram_we, sram_addr, sram_wd, sram_wmask} !== {1'b1, 1'b1, 9'd7, ONES, PAT_M}) begin
            failures++;
            $display("[TB] FAIL mask_issue: ce=%b we=%b addr=%0d wd=%h mask=%h required 1 1 7 ones %h",
                     sram_ce, sram_we, sram_addr, sram_wd, sram_wmask, PAT_M);
        end
        issueReq(1, 1'b0, 9'd7, '0, '0, a);
        repeat (3) @(negedge clk);
        checks++;
        if ({resp_v[1], resp_data[2*DW-1:DW]} !== {1'b1, PAT_M}) begin
            failures++;
            $display("[TB] FAIL partial_mask: rv=%b data=%h required 1 %h", resp_v[1], resp_data[2*DW-1:DW], PAT_M);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] expRdy;
        int prev = 0;
        logic [AW-1:0] addrTab [2];
        logic [DW-1:0] dataTab [2];
        addrTab[0] = 9'd10; addrTab[1] = 9'd20;
        dataTab[0] = 64'h1010_1010_1010_1010; dataTab[1] = 64'h2020_2020_2020_2020;
        @(negedge clk);
        req_we = 2'b11;
        req_addr = {addrTab[1], addrTab[0]};
        req_wdata = {dataTab[1], dataTab[0]};
        req_wmask = {ONES, ONES};
        req_v = 2'b11;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 6) req_v = 2'b00;
            #1;
            if (k > 0) begin
                checks++;
                if ({sram_ce, sram_we, sram_addr, sram_wd} !== {1'b1, 1'b1, addrTab[prev], dataTab[prev]}) begin
                    failures++;
                    $display("[TB] FAIL rr_issue_%0d: ce=%b we=%b addr=%0d wd=%h required 1 1 %0d %h",
                             k, sram_ce, sram_we, sram_addr, sram_wd, addrTab[prev], dataTab[prev]);
                end
            end
            if (k < 6) begin
                expRdy = (expPtr == 0) ? 2'b01 : 2'b10;
                checks++;
                if (req_ready !== expRdy) begin
                    failures++;
                    $display("[TB] FAIL rr_grant_%0d: ready=%b required %b", k, req_ready, expRdy);
                end
                prev = expPtr;
                expPtr = 1 - expPtr;
            end
        end
    endtask

    task automatic test_backpressure();
        int a;
        resp_ready = 2'b01;
        issueReq(1, 1'b0, 9'd5, '0, '0, a);
        repeat (3) @(negedge clk);
        checks++;
        if ({resp_v[1], resp_data[2*DW-1:DW]} !== {1'b1, PAT_A}) begin
            failures++;
            $display("[TB] FAIL bp_first: rv=%b data=%h required 1 %h", resp_v[1], resp_data[2*DW-1:DW], PAT_A);
        end
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            req_v[1] = 1'b1;
            req_we[1] = (k == 8);
            req_addr[2*AW-1:AW] = (k == 8) ? 9'd30 : 9'd7;
            req_wdata[2*DW-1:DW] = 64'h3030_3030_3030_3030;
            req_wmask[2*DW-1:DW] = ONES;
            #1;
            checks++;
            if ({resp_v[1], resp_data[2*DW-1:DW], req_ready[1]} !== {1'b1, PAT_A, (k == 8)}) begin
                failures++;
                $display("[TB] FAIL bp_hold_%0d: rv=%b data=%h ready=%b required 1 %h %b",
                         k, resp_v[1], resp_data[2*DW-1:DW], req_ready[1], PAT_A, (k == 8));
            end
            if (k == 8) expPtr = 0;
        end
        @(negedge clk);
        resp_ready = 2'b11;
        #1;
        checks++;
        if ({resp_v[1], req_ready[1]} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL bp_release: rv=%b ready=%b required 1 1", resp_v[1], req_ready[1]);
        end
        @(negedge clk);
        req_v[1] = 1'b0;
        checks++;
        if (resp_v[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_consumed: rv=%b required 0", resp_v[1]);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({resp_v[1], resp_data[2*DW-1:DW]} !== {1'b1, PAT_M}) begin
            failures++;
            $display("[TB] FAIL bp_second: rv=%b data=%h required 1 %h", resp_v[1], resp_data[2*DW-1:DW], PAT_M);
        end
    endtask

    task automatic test_reset_midflight();
        int a;
        issueReq(0, 1'b0, 9'd5, '0, '0, a);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({resp_v, sram_ce, init_done, req_ready} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL midreset_clear: rv=%b ce=%b done=%b ready=%b required 0", resp_v, sram_ce, init_done, req_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (resp_v !== 2'b00) begin
            failures++;
            $display("[TB] FAIL midreset_hold: rv=%b required 00", resp_v);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({resp_v, sram_ce, sram_we, sram_addr, init_done} !== {2'b00, 1'b1, 1'b1, AW'(i), 1'b0}) begin
                failures++;
                $display("[TB] FAIL resweep_%0d: rv=%b ce=%b we=%b addr=%0d done=%b required 00 1 1 %0d 0",
                         i, resp_v, sram_ce, sram_we, sram_addr, init_done, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_partial_mask();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port 512x64 SRAM macro between two requesters. The macro has a registered read, a per-bit write mask, and a chip enable; read data is valid only in the cycle after an enabled access.
- Round-robin arbitrates one access per cycle, registers all macro inputs, and captures read data into per-requester response holding registers with valid/ready backpressure.
- After reset, sweeps the whole array with zeros so no word is ever X. Sits between the backend pipeline clients and the macro instance.

Parameters:
- BITS, 64, data and mask width.
- WORD_DEPTH, 512, number of words.
- ADDR_WIDTH, 9, address width (log2 WORD_DEPTH).
- INIT_ON_RESET, 1, if 1 run the zero-fill sweep after reset; if 0 go straight to RUN.

Ports:
- clk  in  1  clock; the only clock.
- reset_n  in  1  asynchronous active-low reset.
- req_v_i  in  2  request valid, bit r = requester r.
- req_ready_o  out  2  request accepted when req_v_i[r] & req_ready_o[r].
- req_we_i  in  2  1 = write, 0 = read.
- req_addr_i  in  2*ADDR_WIDTH  word address; slice r.
- req_wdata_i  in  2*BITS  write data; slice r.
- req_wmask_i  in  2*BITS  write bit mask, 1 = write bit; slice r.
- resp_v_o  out  2  read response valid.
- resp_data_o  out  2*BITS  read data; slice r.
- resp_ready_i  in  2  response consumed when resp_v_o[r] & resp_ready_i[r].
- init_done_o  out  1  high once the sweep completes; stays high until reset.
- sram_ce_o  out  1  macro chip enable (registered).
- sram_we_o  out  1  macro write enable (registered).
- sram_addr_o  out  ADDR_WIDTH  macro address (registered).
- sram_wd_o  out  BITS  macro write data (registered).
- sram_wmask_o  out  BITS  macro write mask (registered).
- sram_rd_i  in  BITS  macro read data.

Behaviour:
- Reset (async, reset_n=0) forces:
  - all outputs to 0, including req_ready_o, resp_v_o, resp_data_o, init_done_o and all sram_* outputs;
  - state INIT (RUN if INIT_ON_RESET=0);
  - init counter 0, RR pointer to requester 0, outstanding flags 0, read pipeline empty.
- Reset asserted mid-operation: in-flight reads and held responses are discarded and the sweep restarts.
- FSM states: INIT and RUN.
  - INIT: each cycle issue ce=1, we=1, addr=counter, wd=0, wmask=all ones; counter increments.
  - INIT -> RUN: after the write with addr = WORD_DEPTH-1 is issued; init_done_o rises the next cycle.
  - req_ready_o = 0 throughout INIT.
- Eligibility in RUN, requester r:
  - writes: eligible whenever req_v_i[r]=1;
  - reads: eligible only if outstanding[r]=0, or its held response is consumed this same cycle.
  - req_ready_o[r] = eligible[r] & granted[r]. req_ready_o does not depend on any other requester's ready.
- Arbitration:
  - One grant per cycle.
  - Both eligible: grant the requester named by the RR pointer; pointer then moves to the other requester.
  - One eligible: grant it; pointer moves to the requester not granted.
  - No grant: pointer holds.
- Issue:
  - Granted request is registered onto sram_* on the next edge with ce=1.
  - With no grant, ce=0 and we=0 next cycle; addr, wd and wmask hold.
  - sram_wd_o and sram_wmask_o pass through unmodified; masking is done by the macro.
- Read latency:
  - Accept at cycle t; macro inputs valid at t+1; sram_rd_i valid at t+2.
  - Data is captured into resp_data_o[r] at the end of t+2; resp_v_o[r]=1 from t+3 until consumed.
  - resp_data_o is stable while resp_v_o is high.
- Outstanding tracking:
  - outstanding[r] sets on read accept and clears on response consume.
  - Accept and consume in the same cycle leave it set.
  - At most one read per requester in flight, so one read per 3 cycles per requester when ready is held high.
- Writes produce no response. Ordering is accept order across both requesters.
- A read accepted the cycle after a write to the same address returns the new data.
- sram_rd_i is sampled only in the cycle a read is known to be valid, so its X value when ce=0 never propagates.

Test Plan:
- Reset, INIT_ON_RESET=1 -> exactly 512 cycles with ce=we=1, addr 0..511, wd=0, wmask=all ones; init_done_o high on the next cycle; then any read returns 64'h0.
- Requester 0 writes addr 5 data 64'hDEAD_BEEF_0123_4567 mask all ones, then reads addr 5 -> resp_v_o[0] rises exactly 3 cycles after read accept, data matches.
- Partial mask: write 64'hFFFF... with mask 64'h0000_0000_FFFF_0000 to a zeroed word, then read -> 64'h0000_0000_FFFF_0000.
- Both requesters request continuously (writes) -> grants alternate 0,1,0,1; each granted cycle carries that requester's addr and data.
- Requester 1 read with resp_ready_i[1]=0 for 10 cycles -> resp_v_o[1] held with stable data, req_ready_o[1]=0 for new reads, writes still accepted; the read is accepted in the same cycle resp_ready_i[1] rises.
- reset_n pulsed low while a read is in flight -> resp_v_o=0, no response emerges, the sweep restarts at addr 0.
